// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants for the fetch stage: opcodes, instruction field positions and FSM encoding.
package pc_fetch_unit_pkg;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int unsigned OPCODE_HI = 31;
  localparam int unsigned OPCODE_LO = 27;
  localparam int unsigned ALU_OP_HI = 6;
  localparam int unsigned ALU_OP_LO = 2;
  localparam int unsigned IMM_HI    = 16;
  localparam int unsigned IMM_LO    = 0;
  localparam int unsigned TARGET_HI = 26;
  localparam int unsigned TARGET_LO = 0;

  typedef enum logic [0:0] {
    S_BOOT,
    S_RUN
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: jr, then j/jal, then bex, then taken branch, else pc+1.
module pc_next_sel
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic            valid,
  input  logic [PC_W-1:0] pc,
  input  logic [26:0]     instr_low,
  input  logic            is_bne,
  input  logic            is_blt,
  input  logic            is_j1,
  input  logic            is_j2,
  input  logic            is_bex,
  input  logic            cond_ne,
  input  logic            cond_lt,
  input  logic            cond_bex,
  input  logic [31:0]     jr_target,
  output logic [PC_W-1:0] next_pc,
  output logic            taken
);

  logic [PC_W-1:0] seq_pc;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] offset;
  logic            br_taken;

  assign seq_pc   = pc + PC_W'(1);
  assign target   = PC_W'(instr_low[TARGET_HI:TARGET_LO]);
  assign offset   = PC_W'($signed(instr_low[IMM_HI:IMM_LO]));
  assign br_taken = (is_bne & cond_ne) | (is_blt & cond_lt);

  always_comb begin
    next_pc = seq_pc;
    taken   = 1'b0;
    // Strobes are meaningless unless the presented word belongs to pc.
    if (valid) begin
      if (is_j2) begin
        next_pc = PC_W'(jr_target);
        taken   = 1'b1;
      end else if (is_j1 || (is_bex && cond_bex)) begin
        next_pc = target;
        taken   = 1'b1;
      end else if (br_taken) begin
        next_pc = seq_pc + offset;
        taken   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch front end. Optional perf counters under
// PC_FETCH_PERF_CNT_EN; without it retired_cnt/redirect_cnt are tied to zero.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [31:0]       instr_in,
  input  logic              is_bne,
  input  logic              is_blt,
  input  logic              is_j1,
  input  logic              is_j2,
  input  logic              is_bex,
  input  logic              cond_ne,
  input  logic              cond_lt,
  input  logic              cond_bex,
  input  logic [31:0]       jr_target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [PC_W-1:0]   pc,
  output logic [PC_W-1:0]   pc_plus1,
  output logic [4:0]        opcode,
  output logic [4:0]        alu_op,
  output logic              instr_valid,
  output logic              redirect,
  output logic [31:0]       retired_cnt,
  output logic [31:0]       redirect_cnt
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc;
  logic            taken;
  logic            pc_en;

  pc_next_sel #(
    .PC_W(PC_W)
  ) u_next_sel (
    .valid     (instr_valid),
    .pc        (pc_q),
    .instr_low (instr_in[26:0]),
    .is_bne    (is_bne),
    .is_blt    (is_blt),
    .is_j1     (is_j1),
    .is_j2     (is_j2),
    .is_bex    (is_bex),
    .cond_ne   (cond_ne),
    .cond_lt   (cond_lt),
    .cond_bex  (cond_bex),
    .jr_target (jr_target),
    .next_pc   (next_pc),
    .taken     (taken)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_comb begin
    instr_valid = (state_q == S_RUN);
    pc_en       = instr_valid & ~stall;
    redirect    = pc_en & taken;
    opcode      = instr_valid ? instr_in[OPCODE_HI:OPCODE_LO] : 5'd0;
    alu_op      = instr_valid ? instr_in[ALU_OP_HI:ALU_OP_LO] : 5'd0;
    // Address one ahead so the synchronous memory returns mem[pc] while pc is current;
    // on a stall re-read the current word.
    if (!instr_valid) begin
      imem_addr = '0;
    end else if (stall) begin
      imem_addr = pc_q[ADDR_W-1:0];
    end else begin
      imem_addr = next_pc[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= '0;
    end else if (pc_en) begin
      pc_q <= next_pc;
    end
  end

  assign pc       = pc_q;
  assign pc_plus1 = pc_q + PC_W'(1);

`ifdef PC_FETCH_PERF_CNT_EN
  logic [31:0] retired_q;
  logic [31:0] redirect_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      retired_q  <= '0;
      redirect_q <= '0;
    end else begin
      if (pc_en) begin
        retired_q <= retired_q + 32'd1;
      end
      if (redirect) begin
        redirect_q <= redirect_q + 32'd1;
      end
    end
  end

  assign retired_cnt  = retired_q;
  assign redirect_cnt = redirect_q;
`else
  assign retired_cnt  = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: synchronous memory model, behavioural next-PC model checked every
// cycle, directed scenarios with literal expectations, then randomized strobes/stalls/resets.
module tb_pc_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instr_in = 32'd0;
  logic        is_bne = 1'b0, is_blt = 1'b0, is_j1 = 1'b0, is_j2 = 1'b0, is_bex = 1'b0;
  logic        cond_ne = 1'b0, cond_lt = 1'b0, cond_bex = 1'b0;
  logic [31:0] jr_target = 32'd0;
  logic [11:0] imem_addr;
  logic [31:0] pc, pc_plus1, retired_cnt, redirect_cnt;
  logic [4:0]  opcode, alu_op;
  logic        instr_valid, redirect;

  pc_fetch_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .instr_in     (instr_in),
    .is_bne       (is_bne),
    .is_blt       (is_blt),
    .is_j1        (is_j1),
    .is_j2        (is_j2),
    .is_bex       (is_bex),
    .cond_ne      (cond_ne),
    .cond_lt      (cond_lt),
    .cond_bex     (cond_bex),
    .jr_target    (jr_target),
    .imem_addr    (imem_addr),
    .pc           (pc),
    .pc_plus1     (pc_plus1),
    .opcode       (opcode),
    .alu_op       (alu_op),
    .instr_valid  (instr_valid),
    .redirect     (redirect),
    .retired_cnt  (retired_cnt),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [0:4095];
  logic [11:0] rd_addr = 12'd0;
  int total = 0;
  int bad = 0;

  // Model state describes the cycle currently presented by the DUT.
  logic        m_known = 1'b0;
  logic        m_run = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_ret = 32'd0;
  logic [31:0] m_red = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {taken, next_pc} straight from the selection rules.
  function automatic logic [32:0] model_next(input logic v, input logic [31:0] p,
                                             input logic [31:0] ins);
    logic [31:0] seq;
    logic [31:0] tgt;
    logic [31:0] imm;
    seq = p + 32'd1;
    tgt = {5'd0, ins[26:0]};
    imm = {{15{ins[16]}}, ins[16:0]};
    if (!v) return {1'b0, seq};
    if (is_j2) return {1'b1, jr_target};
    if (is_j1) return {1'b1, tgt};
    if (is_bex && cond_bex) return {1'b1, tgt};
    if ((is_bne && cond_ne) || (is_blt && cond_lt)) return {1'b1, seq + imm};
    return {1'b0, seq};
  endfunction

  always @(negedge clock) begin
    logic [32:0] nx;
    logic [31:0] exp_addr;
    logic [31:0] exp_ret;
    logic [31:0] exp_red;
    nx = model_next(m_run, m_pc, instr_in);
    if (!m_run) exp_addr = 32'd0;
    else if (stall) exp_addr = {20'd0, m_pc[11:0]};
    else exp_addr = {20'd0, nx[11:0]};
`ifdef PC_FETCH_PERF_CNT_EN
    exp_ret = m_ret;
    exp_red = m_red;
`else
    exp_ret = 32'd0;
    exp_red = 32'd0;
`endif
    if (m_known) begin
      chk("pc", pc, m_pc);
      chk("pc_plus1", pc_plus1, m_pc + 32'd1);
      chk("instr_valid", 32'(instr_valid), 32'(m_run));
      chk("opcode", 32'(opcode), m_run ? 32'(instr_in[31:27]) : 32'd0);
      chk("alu_op", 32'(alu_op), m_run ? 32'(instr_in[6:2]) : 32'd0);
      chk("imem_addr", 32'(imem_addr), exp_addr);
      chk("redirect", 32'(redirect), 32'(m_run & ~stall & nx[32]));
      chk("retired_cnt", retired_cnt, exp_ret);
      chk("redirect_cnt", redirect_cnt, exp_red);
    end
    rd_addr = imem_addr;
    if (reset) begin
      m_known = 1'b1;
      m_run   = 1'b0;
      m_pc    = 32'd0;
      m_ret   = 32'd0;
      m_red   = 32'd0;
    end else if (m_known) begin
      if (!m_run) begin
        m_run = 1'b1;
      end else if (!stall) begin
        m_pc  = nx[31:0];
        m_ret = m_ret + 32'd1;
        if (nx[32]) m_red = m_red + 32'd1;
      end
    end
  end

  // Start a new cycle: memory returns the word addressed last cycle, strobes go idle.
  task automatic tick();
    @(posedge clock);
    #1;
    instr_in  = mem[rd_addr];
    stall     = 1'b0;
    is_bne    = 1'b0;
    is_blt    = 1'b0;
    is_j1     = 1'b0;
    is_j2     = 1'b0;
    is_bex    = 1'b0;
    cond_ne   = 1'b0;
    cond_lt   = 1'b0;
    cond_bex  = 1'b0;
    jr_target = 32'd0;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic run_to(input logic [31:0] t);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (m_run && m_pc == t) return;
      settle();
    end
    total++;
    bad++;
    $display("FAIL run_to: pc=%h never reached target %h", pc, t);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[5]  = {5'b00010, 10'd0, 17'h1FFFD};
    mem[8]  = {5'b00001, 27'd100};
    mem[10] = {5'b10110, 27'd40};
    mem[12] = {5'b00010, 10'd0, 17'd20};
    mem[33] = {5'b00011, 27'd50};
    mem[40] = {5'b00001, 27'd77};

    // Reset release and sequential fetch
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); settle(); end
    tick(); reset = 1'b0; settle();
    chk("boot_pc", pc, 32'd0);
    chk("boot_valid", 32'(instr_valid), 32'd0);
    chk("boot_addr", 32'(imem_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick(); settle();
      chk("seq_pc", pc, 32'(k));
      chk("seq_addr", 32'(imem_addr), 32'(k + 1));
      chk("seq_redirect", 32'(redirect), 32'd0);
    end

    // Branch taken then not taken
    run_to(32'd5); is_bne = 1'b1; cond_ne = 1'b1; settle();
    chk("bne_taken_redirect", 32'(redirect), 32'd1);
    chk("bne_taken_addr", 32'(imem_addr), 32'd3);
    tick(); settle(); chk("bne_taken_pc", pc, 32'd3);
    run_to(32'd5); is_bne = 1'b1; cond_ne = 1'b0; settle();
    chk("bne_nt_redirect", 32'(redirect), 32'd0);
    tick(); settle(); chk("bne_nt_pc", pc, 32'd6);

    // Jumps
    run_to(32'd8); is_j1 = 1'b1; settle();
    chk("jal_link", pc_plus1, 32'd9);
    tick(); is_j2 = 1'b1; jr_target = 32'd9; settle();
    chk("j_pc", pc, 32'd100);
    tick(); is_bex = 1'b1; cond_bex = 1'b0; settle();
    chk("jr_pc", pc, 32'd9);
    chk("bex_nt_redirect", 32'(redirect), 32'd0);
    tick(); is_bex = 1'b1; cond_bex = 1'b1; settle();
    chk("bex_nt_pc", pc, 32'd10);
    tick(); is_j2 = 1'b1; is_j1 = 1'b1; jr_target = 32'd12; settle();
    chk("bex_taken_pc", pc, 32'd40);
    tick(); settle();
    chk("prio_pc", pc, 32'd12);

    // Stall holds a taken branch
    for (int i = 0; i < 4; i++) begin
      stall = 1'b1; is_bne = 1'b1; cond_ne = 1'b1; settle();
      chk("stall_pc", pc, 32'd12);
      chk("stall_redirect", 32'(redirect), 32'd0);
      chk("stall_addr", 32'(imem_addr), 32'd12);
      tick();
    end
    is_bne = 1'b1; cond_ne = 1'b1; settle();
    chk("unstall_redirect", 32'(redirect), 32'd1);
    tick(); is_j1 = 1'b1; settle();
    chk("unstall_pc", pc, 32'd33);
    tick(); reset = 1'b1; settle();
    chk("jal50_pc", pc, 32'd50);
    tick(); settle();
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);

    // Wrap
    tick(); reset = 1'b0; settle();
    tick(); is_j2 = 1'b1; jr_target = 32'hFFFF_FFFF; settle();
    tick(); settle();
    chk("wrap_pc", pc, 32'hFFFF_FFFF);
    chk("wrap_addr", 32'(imem_addr), 32'd0);
    chk("wrap_plus1", pc_plus1, 32'd0);
    tick(); settle();
    chk("wrap_pc0", pc, 32'd0);

    // Counters: 10 retired, 3 redirects
    tick(); reset = 1'b1; settle();
    tick(); reset = 1'b0; settle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 1 || i == 4 || i == 7) is_j1 = 1'b1;
      settle();
    end
    tick(); settle();
`ifdef PC_FETCH_PERF_CNT_EN
    chk("retired_10", retired_cnt, 32'd10);
    chk("redirect_3", redirect_cnt, 32'd3);
`else
    chk("retired_off", retired_cnt, 32'd0);
    chk("redirect_off", redirect_cnt, 32'd0);
`endif

    // Randomized phase
    for (int n = 0; n < 3000; n++) begin
      int r;
      tick();
      reset     = ($urandom_range(0, 149) == 0);
      stall     = ($urandom_range(0, 6) == 0);
      cond_ne   = 1'($urandom);
      cond_lt   = 1'($urandom);
      cond_bex  = 1'($urandom);
      jr_target = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095));
      r = $urandom_range(0, 15);
      case (r)
        0: is_j2 = 1'b1;
        1: is_j1 = 1'b1;
        2: is_bex = 1'b1;
        3: is_bne = 1'b1;
        4: is_blt = 1'b1;
        5: begin is_j2 = 1'b1; is_j1 = 1'b1; end
        6: begin is_bne = 1'b1; is_blt = 1'b1; is_bex = 1'b1; end
        default: ;
      endcase
      settle();
    end
    tick(); reset = 1'b0; settle();
    tick(); settle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
